// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM state encoding
// and default datapath widths.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } alu_state_e;

  // Width of a requester index / round-robin pointer for n requesters.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: the first asserted request at or after
// ptr (wrapping modulo N) receives a one-hot grant.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   pos_s;
  logic found_s;

  // Scan requesters starting at the pointer; the first hit takes the grant.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < N; k++) begin
      pos_s        = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      grant[pos_s] = req[pos_s] & ~found_s;
      found_s      = found_s | req[pos_s];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for a single shared ALU: accept, setup, one-cycle
// enable pulse, capture, respond. Define ALU_DIVZERO_CHECK_EN to short-circuit
// divide-by-zero requests with an all-ones result and rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      alu_enable,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_n1,
  output logic [DATA_W-1:0]         alu_n2,
  input  logic [DATA_W-1:0]         alu_out
);

  localparam int PW = idx_width(NUM_REQ);

  alu_state_e          state_r;
  logic [PW-1:0]       ptr_r;
  logic [NUM_REQ-1:0]  owner_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;
  logic                alu_enable_r;
  logic [OP_W-1:0]     alu_op_r;
  logic [DATA_W-1:0]   alu_n1_r;
  logic [DATA_W-1:0]   alu_n2_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [PW-1:0]       gidx_s;
  logic [PW-1:0]       ptr_next_s;
  logic                accept_s;
  logic                owner_done_s;
  logic [OP_W-1:0]     sel_op_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Offer the grant only while idle and out of reset.
  always_comb begin
    if ((state_r == IDLE) && !reset) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Encode the one-hot grant and select that requester's payload.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s = gidx_s | (grant_s[i] ? PW'(i) : '0);
    end
    ptr_next_s   = (gidx_s == PW'(NUM_REQ - 1)) ? '0 : (gidx_s + PW'(1));
    sel_op_s     = req_op[gidx_s*OP_W +: OP_W];
    sel_a_s      = req_a[gidx_s*DATA_W +: DATA_W];
    sel_b_s      = req_b[gidx_s*DATA_W +: DATA_W];
    accept_s     = |(req_valid & req_ready_s);
    owner_done_s = |(rsp_ready & owner_r);
  end

  // Operation sequencer; every output it drives is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      owner_r      <= '0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
      rsp_err_r    <= 1'b0;
      alu_enable_r <= 1'b0;
      alu_op_r     <= '0;
      alu_n1_r     <= '0;
      alu_n2_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_op_r <= sel_op_s;
            alu_n1_r <= sel_a_s;
            alu_n2_r <= sel_b_s;
            owner_r  <= grant_s;
            ptr_r    <= ptr_next_s;
`ifdef ALU_DIVZERO_CHECK_EN
            if ((sel_op_s == OP_W'(ALU_DIV)) && (sel_b_s == '0)) begin
              rsp_valid_r <= grant_s;
              rsp_data_r  <= '1;
              rsp_err_r   <= 1'b1;
              state_r     <= RESP;
            end else begin
              state_r <= SETUP;
            end
`else
            state_r <= SETUP;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          alu_enable_r <= 1'b1;
          state_r      <= EXEC;
        end
        EXEC: begin
          // Enable rises at the start of EXEC; the ALU result is ready by its end.
          alu_enable_r <= 1'b0;
          rsp_data_r   <= alu_out;
          rsp_err_r    <= 1'b0;
          rsp_valid_r  <= owner_r;
          state_r      <= RESP;
        end
        RESP: begin
          if (owner_done_s) begin
            rsp_valid_r <= '0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          alu_enable_r <= 1'b0;
          rsp_valid_r  <= '0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;
  assign alu_enable = alu_enable_r;
  assign alu_op     = alu_op_r;
  assign alu_n1     = alu_n1_r;
  assign alu_n2     = alu_n2_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural 4-bit ALU
// that evaluates on the rising edge of its enable input.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       alu_enable;
  logic [1:0] alu_op;
  logic [3:0] alu_n1;
  logic [3:0] alu_n2;
  logic [3:0] alu_out = 4'h0;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_enable (alu_enable),
    .alu_op     (alu_op),
    .alu_n1     (alu_n1),
    .alu_n2     (alu_n2),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  // External ALU stand-in: computes only when enable rises; x/0 returns all ones.
  always @(posedge alu_enable) begin
    case (alu_op)
      2'b00:   alu_out = alu_n1 + alu_n2;
      2'b01:   alu_out = alu_n1 - alu_n2;
      2'b10:   alu_out = alu_n1 * alu_n2;
      default: alu_out = (alu_n2 == 4'h0) ? 4'hF : (alu_n1 / alu_n2);
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One uncontended operation from requester idx with response accepted at once.
  task automatic run_op(input int idx, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] exp_d, input string tag);
    logic [1:0] oh;
    oh = 2'b01 << idx;
    req_valid = oh;
    req_op[idx*2 +: 2] = op;
    req_a[idx*4 +: 4]  = a;
    req_b[idx*4 +: 4]  = b;
    rsp_ready = 2'b11;
    #1;
    chk({tag, "_ready"}, 8'(req_ready), 8'(oh));
    @(negedge clk);
    chk({tag, "_setup_en"}, 8'(alu_enable), 8'h00);
    chk({tag, "_n1"}, 8'(alu_n1), 8'(a));
    chk({tag, "_n2"}, 8'(alu_n2), 8'(b));
    chk({tag, "_op"}, 8'(alu_op), 8'(op));
    req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_exec_en"}, 8'(alu_enable), 8'h01);
    chk({tag, "_exec_vld"}, 8'(rsp_valid), 8'h00);
    @(negedge clk);
    chk({tag, "_resp_en"}, 8'(alu_enable), 8'h00);
    chk({tag, "_resp_vld"}, 8'(rsp_valid), 8'(oh));
    chk({tag, "_data"}, 8'(rsp_data), 8'(exp_d));
    chk({tag, "_err"}, 8'(rsp_err), 8'h00);
    @(negedge clk);
    chk({tag, "_idle_vld"}, 8'(rsp_valid), 8'h00);
  endtask

  initial begin
    // Reset with requests pending: they must be ignored.
    reset = 1'b1;
    req_valid = 2'b11;
    req_op = 4'b0000;
    req_a = 8'h21;
    req_b = 8'h43;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 8'(req_ready), 8'h00);
    chk("rst_en", 8'(alu_enable), 8'h00);
    chk("rst_vld", 8'(rsp_valid), 8'h00);
    chk("rst_data", 8'(rsp_data), 8'h00);
    chk("rst_err", 8'(rsp_err), 8'h00);
    chk("rst_n1", 8'(alu_n1), 8'h00);
    chk("rst_n2", 8'(alu_n2), 8'h00);
    chk("rst_op", 8'(alu_op), 8'h00);
    req_valid = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_noreq", 8'(req_ready), 8'h00);

    // Single add: 3 + 4.
    run_op(0, 2'b00, 4'd3, 4'd4, 4'd7, "add");

    // Fresh reset, then both requesters contend.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b11;
    req_op = {2'b10, 2'b01};
    req_a  = {4'd6, 4'd9};
    req_b  = {4'd3, 4'd2};
    rsp_ready = 2'b11;
    #1;
    chk("ct_ready0", 8'(req_ready), 8'h01);
    @(negedge clk);
    chk("ct_setup_rdy", 8'(req_ready), 8'h00);
    chk("ct_n1_0", 8'(alu_n1), 8'd9);
    @(negedge clk);
    chk("ct_en0", 8'(alu_enable), 8'h01);
    @(negedge clk);
    chk("ct_vld0", 8'(rsp_valid), 8'h01);
    chk("ct_data0", 8'(rsp_data), 8'd7);
    @(negedge clk);
    chk("ct_ready1", 8'(req_ready), 8'h02);
    @(negedge clk);
    chk("ct_n1_1", 8'(alu_n1), 8'd6);
    chk("ct_op1", 8'(alu_op), 8'h02);
    @(negedge clk);
    chk("ct_en1", 8'(alu_enable), 8'h01);
    @(negedge clk);
    chk("ct_vld1", 8'(rsp_valid), 8'h02);
    chk("ct_data1", 8'(rsp_data), 8'd2);
    @(negedge clk);
    chk("ct_ready2", 8'(req_ready), 8'h01);
    req_valid = 2'b00;
    @(negedge clk);

    // Backpressure: 15 + 1 with the owner not ready; non-owner ready is ignored.
    req_valid = 2'b01;
    req_op = 4'b0000;
    req_a = {4'd1, 4'd15};
    req_b = {4'd2, 4'd1};
    rsp_ready = 2'b00;
    #1;
    chk("bp_ready", 8'(req_ready), 8'h01);
    @(negedge clk);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    #1;
    chk("bp_setup_rdy", 8'(req_ready), 8'h00);
    @(negedge clk);
    chk("bp_exec_rdy", 8'(req_ready), 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_vld", 8'(rsp_valid), 8'h01);
      chk("bp_hold_data", 8'(rsp_data), 8'h00);
      chk("bp_hold_rdy", 8'(req_ready), 8'h00);
      chk("bp_hold_en", 8'(alu_enable), 8'h00);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_done_vld", 8'(rsp_valid), 8'h00);
    chk("bp_next_rdy", 8'(req_ready), 8'h02);
    req_valid = 2'b00;
    @(negedge clk);

    // Reset while in EXEC drops the operation.
    req_valid = 2'b01;
    req_op = 4'b0000;
    req_a = 8'h11;
    req_b = 8'h11;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rx_en_before", 8'(alu_enable), 8'h01);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_en", 8'(alu_enable), 8'h00);
    chk("rx_vld", 8'(rsp_valid), 8'h00);
    chk("rx_n1", 8'(alu_n1), 8'h00);
    chk("rx_data", 8'(rsp_data), 8'h00);
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rx_ptr0", 8'(req_ready), 8'h01);

    // Requester 1 divides 12 / 5.
    run_op(1, 2'b11, 4'd12, 4'd5, 4'd2, "div");

    // Divide by zero, 7 / 0.
`ifdef ALU_DIVZERO_CHECK_EN
    req_valid = 2'b01;
    req_op[1:0] = 2'b11;
    req_a[3:0] = 4'd7;
    req_b[3:0] = 4'd0;
    rsp_ready = 2'b11;
    #1;
    chk("dz_ready", 8'(req_ready), 8'h01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("dz_vld", 8'(rsp_valid), 8'h01);
    chk("dz_data", 8'(rsp_data), 8'h0F);
    chk("dz_err", 8'(rsp_err), 8'h01);
    chk("dz_en", 8'(alu_enable), 8'h00);
    @(negedge clk);
    chk("dz_idle_vld", 8'(rsp_valid), 8'h00);
    chk("dz_idle_en", 8'(alu_enable), 8'h00);
`else
    run_op(0, 2'b11, 4'd7, 4'd0, 4'hF, "dz");
`endif

    // Wrap-around arithmetic.
    run_op(1, 2'b00, 4'd9, 4'd9, 4'd2, "addwrap");
    run_op(0, 2'b01, 4'd2, 4'd5, 4'd13, "subwrap");
    run_op(1, 2'b10, 4'd5, 4'd5, 4'd9, "multrunc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
